traffic_ctrl: RTL

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

---
 rtl/traffic_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl.sv
// Two-approach traffic light controller with pedestrian walk phase and night flashing.
// All phases share one down-counting timer reloaded with duration-1 on every entry.
module traffic_ctrl #(
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10,
  parameter int FLASH_T  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] light_a,
  output logic [2:0] light_b,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED_1 = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    ALLRED_2 = 3'd5,
    WALK     = 3'd6,
    FLASH    = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             blink_q, blink_d;
  logic             pend_q,  pend_d;
  logic             ack_q,   ack_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLRED_2;
      timer_q <= ALLRED_LD;
      blink_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    blink_d = blink_q;
    ack_d   = 1'b0;
    // Request capture runs even while frozen; WALK entry overrides it below.
    pend_d  = pend_q | ped_req;
    if (enable) begin
      if (timer_q == '0) begin
        unique case (state_q)
          A_GREEN: begin
            state_d = A_YELLOW;
            timer_d = YELLOW_LD;
          end
          A_YELLOW: begin
            state_d = ALLRED_1;
            timer_d = ALLRED_LD;
          end
          ALLRED_1: begin
            if (flash_mode) begin
              state_d = FLASH;
              timer_d = FLASH_LD;
              blink_d = 1'b1;
            end else begin
              state_d = B_GREEN;
              timer_d = GREEN_LD;
            end
          end
          B_GREEN: begin
            state_d = B_YELLOW;
            timer_d = YELLOW_LD;
          end
          B_YELLOW: begin
            state_d = ALLRED_2;
            timer_d = ALLRED_LD;
          end
          ALLRED_2: begin
            if (flash_mode) begin
              state_d = FLASH;
              timer_d = FLASH_LD;
              blink_d = 1'b1;
            end else if (pend_d) begin
              state_d = WALK;
              timer_d = WALK_LD;
              pend_d  = 1'b0;
              ack_d   = 1'b1;
            end else begin
              state_d = A_GREEN;
              timer_d = GREEN_LD;
            end
          end
          WALK: begin
            state_d = A_GREEN;
            timer_d = GREEN_LD;
          end
          FLASH: begin
            // Exit is only considered at a blink boundary.
            blink_d = ~blink_q;
            if (!flash_mode) begin
              state_d = ALLRED_2;
              timer_d = ALLRED_LD;
            end else begin
              timer_d = FLASH_LD;
            end
          end
          default: begin
            state_d = ALLRED_2;
            timer_d = ALLRED_LD;
          end
        endcase
      end else begin
        timer_d = timer_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    light_a = LAMP_RED;
    light_b = LAMP_RED;
    unique case (state_q)
      A_GREEN:  light_a = LAMP_GREEN;
      A_YELLOW: light_a = LAMP_YELLOW;
      B_GREEN:  light_b = LAMP_GREEN;
      B_YELLOW: light_b = LAMP_YELLOW;
      FLASH: begin
        light_a = blink_q ? LAMP_YELLOW : LAMP_DARK;
        light_b = blink_q ? LAMP_RED    : LAMP_DARK;
      end
      default: begin
        light_a = LAMP_RED;
        light_b = LAMP_RED;
      end
    endcase
  end

  assign walk    = (state_q == WALK);
  assign ped_ack = ack_q;
  assign phase   = state_q;

endmodule
